// File: rtl/calc_cmd_dispatcher.sv
// Command front-end for the MP calculator: queues host commands, issues them one at a time,
// waits the opcode's fixed latency and holds each result in a valid/ready register.
module calc_cmd_dispatcher #(
  parameter int DEPTH      = 4,
  parameter int LAT_SIMPLE = 10,
  parameter int LAT_CMUL   = 44,
  parameter int LAT_CDIV   = 96
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_opcode,
  input  logic [15:0]             cmd_a,
  input  logic [15:0]             cmd_b,
  input  logic [15:0]             cmd_c,
  input  logic [15:0]             cmd_d,
  output logic [15:0]             calc_A,
  output logic [15:0]             calc_B,
  output logic [15:0]             calc_C,
  output logic [15:0]             calc_D,
  output logic [7:0]              calc_opcode,
  output logic                    calc_compute,
  input  logic [15:0]             calc_out,
  input  logic [15:0]             calc_im,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [15:0]             res_out,
  output logic [15:0]             res_im,
  output logic [7:0]              res_opcode,
  output logic                    res_err,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LAT_MAX = (LAT_CDIV > LAT_CMUL)
                           ? ((LAT_CDIV > LAT_SIMPLE) ? LAT_CDIV : LAT_SIMPLE)
                           : ((LAT_CMUL > LAT_SIMPLE) ? LAT_CMUL : LAT_SIMPLE);
  localparam int CW      = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t          state;
  state_t          state_next;
  logic [71:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            ready_en;
  logic            push;
  logic            pop;
  logic [71:0]     head;
  logic [7:0]      head_op;
  logic            head_bad;
  logic [7:0]      cur_opcode;
  logic            cur_err;
  logic [CW-1:0]   cnt;

  function automatic logic [CW-1:0] lat_minus1(input logic [7:0] op);
    case (op)
      8'd6:    return CW'(LAT_CMUL - 1);
      8'd7:    return CW'(LAT_CDIV - 1);
      default: return CW'(LAT_SIMPLE - 1);
    endcase
  endfunction

  // ready_en keeps cmd_ready low through reset and for the first edge after it
  assign cmd_ready = ready_en && (fifo_count != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0) && !res_valid;
  assign head      = mem[rd_ptr];
  assign head_op   = head[71:64];
  assign head_bad  = head_op > 8'd9;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bad opcodes skip ISSUE/WAIT entirely so the calculator never sees them
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = head_bad ? CAPTURE : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    calc_compute = (state == ISSUE);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      calc_A      <= '0;
      calc_B      <= '0;
      calc_C      <= '0;
      calc_D      <= '0;
      calc_opcode <= '0;
      cur_opcode  <= '0;
      cur_err     <= 1'b0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_out     <= '0;
      res_im      <= '0;
      res_opcode  <= '0;
      res_err     <= 1'b0;
    end else begin
      if (pop) begin
        cur_opcode <= head_op;
        cur_err    <= head_bad;
        if (!head_bad) begin
          calc_opcode <= head_op;
          calc_A      <= head[63:48];
          calc_B      <= head[47:32];
          calc_C      <= head[31:16];
          calc_D      <= head[15:0];
        end
      end
      if (state == ISSUE)
        cnt <= lat_minus1(calc_opcode);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == CAPTURE) begin
        res_valid  <= 1'b1;
        res_out    <= cur_err ? 16'h0 : calc_out;
        res_im     <= cur_err ? 16'h0 : calc_im;
        res_opcode <= cur_opcode;
        res_err    <= cur_err;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
